residual_skip_adder: RTL and testbench

//   Parametrised residual-join stage for inverted residual blocks.
//   - Buffers the block-input (skip) stream in an internal FIFO.
//   - Joins each skip beat with the main-path (post-BN) stream using signed,

---
 rtl/residual_skip_adder.sv | 146 ++++++++++++++
 tb/tb_residual_skip_adder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/residual_skip_adder.sv
// Residual join: skip stream buffered in a FIFO, shifted and added to the main stream with saturation and optional ReLU.
// Latency: 1 cycle from a main/skip pairing to m_axis. Full throughput, one beat per clock.
// Backpressure: main stalls on an empty FIFO or a held output; skip stalls only on a full FIFO.
module residual_skip_adder #(
    parameter int DATA_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 2048,
    parameter int SHIFT_WIDTH   = 4,
    parameter int SAT_CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         s_skip_tdata,
    input  logic                          s_skip_tvalid,
    output logic                          s_skip_tready,
    input  logic                          s_skip_tlast,
    input  logic [DATA_WIDTH-1:0]         s_main_tdata,
    input  logic                          s_main_tvalid,
    output logic                          s_main_tready,
    input  logic                          s_main_tlast,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic [1:0]                    cfg_mode,
    input  logic [SHIFT_WIDTH-1:0]        cfg_main_shift,
    input  logic [SHIFT_WIDTH-1:0]        cfg_skip_shift,
    input  logic                          clear_status,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err_last_mismatch,
    output logic [SAT_CNT_WIDTH-1:0]      sat_count,
    output logic                          frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                   r_state, w_state_nxt;
    logic [1:0]               r_mode;
    logic [SHIFT_WIDTH-1:0]   r_main_shift, r_skip_shift;
    logic [DATA_WIDTH:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]              r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0]    r_tdata;
    logic                     r_tvalid, r_tlast, r_err;
    logic [SAT_CNT_WIDTH-1:0] r_sat;

    logic [1:0]                   w_cfg_mode_n, w_mode;
    logic [SHIFT_WIDTH-1:0]       w_main_shift, w_skip_shift;
    logic                         w_bypass, w_empty, w_full, w_out_free;
    logic                         w_fire, w_push, w_pop, w_skip_rdy;
    logic [DATA_WIDTH:0]          w_skip_word;
    logic signed [DATA_WIDTH-1:0] w_a, w_b;
    logic [DATA_WIDTH:0]          w_sum;
    logic                         w_ovf, w_sat_beat, w_mismatch;
    logic [DATA_WIDTH-1:0]        w_clamped, w_relu, w_result;

    // Mode 3 aliases mode 1; cfg is live while idle and frozen for the rest of a frame.
    assign w_cfg_mode_n = (cfg_mode == 2'd3) ? 2'd1 : cfg_mode;
    assign w_mode       = (r_state == ST_RUN) ? r_mode       : w_cfg_mode_n;
    assign w_main_shift = (r_state == ST_RUN) ? r_main_shift : cfg_main_shift;
    assign w_skip_shift = (r_state == ST_RUN) ? r_skip_shift : cfg_skip_shift;
    assign w_bypass     = (w_mode == 2'd0);

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_skip_word = r_mem[r_rd_ptr[AW-1:0]];

    assign w_out_free = !r_tvalid || m_axis_tready;
    assign w_skip_rdy = rst_n && (w_bypass || !w_full);
    assign w_fire     = rst_n && s_main_tvalid && w_out_free && (w_bypass || !w_empty);
    assign w_push     = s_skip_tvalid && w_skip_rdy && !w_bypass;
    assign w_pop      = w_fire && !w_bypass;

    assign w_a   = $signed(s_main_tdata) >>> w_main_shift;
    assign w_b   = $signed(w_skip_word[DATA_WIDTH-1:0]) >>> w_skip_shift;
    assign w_sum = {w_a[DATA_WIDTH-1], w_a} + {w_b[DATA_WIDTH-1], w_b};
    // Overflow shows as the two top bits of the widened sum disagreeing.
    assign w_ovf = w_sum[DATA_WIDTH] ^ w_sum[DATA_WIDTH-1];
    assign w_clamped = !w_ovf         ? w_sum[DATA_WIDTH-1:0] :
                       w_sum[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                           {1'b0, {(DATA_WIDTH-1){1'b1}}};
    assign w_relu     = (w_mode == 2'd2 && w_clamped[DATA_WIDTH-1]) ? '0 : w_clamped;
    assign w_result   = w_bypass ? s_main_tdata : w_relu;
    assign w_sat_beat = !w_bypass && w_ovf;
    assign w_mismatch = !w_bypass && (w_skip_word[DATA_WIDTH] != s_main_tlast);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_fire && !s_main_tlast) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_fire && s_main_tlast)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {s_skip_tlast, s_skip_tdata};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mode       <= 2'd0;
            r_main_shift <= '0;
            r_skip_shift <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_err        <= 1'b0;
            r_sat        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_fire) begin
                r_mode       <= w_cfg_mode_n;
                r_main_shift <= cfg_main_shift;
                r_skip_shift <= cfg_skip_shift;
            end
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            if (w_fire) begin
                r_tdata  <= w_result;
                r_tvalid <= 1'b1;
                r_tlast  <= s_main_tlast;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (clear_status)                  r_err <= 1'b0;
            else if (w_fire && w_mismatch)     r_err <= 1'b1;
            if (clear_status)                  r_sat <= '0;
            else if (w_fire && w_sat_beat && r_sat != '1)
                                               r_sat <= r_sat + SAT_CNT_WIDTH'(1);
        end
    end

    assign s_skip_tready     = w_skip_rdy;
    assign s_main_tready     = w_fire;
    assign m_axis_tdata      = r_tdata;
    assign m_axis_tvalid     = r_tvalid;
    assign m_axis_tlast      = r_tlast;
    assign fifo_level        = r_wr_ptr - r_rd_ptr;
    assign err_last_mismatch = r_err;
    assign sat_count         = r_sat;
    assign frame_done        = r_tvalid && m_axis_tready && r_tlast;

endmodule

// File: tb/tb_residual_skip_adder.sv
// Directed bench for residual_skip_adder with an arithmetic reference model and an output scoreboard.
module tb_residual_skip_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] s_skip_tdata, s_main_tdata, m_axis_tdata;
    logic        s_skip_tvalid, s_skip_tready, s_skip_tlast;
    logic        s_main_tvalid, s_main_tready, s_main_tlast;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_main_shift, cfg_skip_shift;
    logic        clear_status;
    logic [2:0]  fifo_level;
    logic        err_last_mismatch, frame_done;
    logic [15:0] sat_count;

    residual_skip_adder #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .SHIFT_WIDTH(4), .SAT_CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_skip_tdata(s_skip_tdata), .s_skip_tvalid(s_skip_tvalid), .s_skip_tready(s_skip_tready),
        .s_skip_tlast(s_skip_tlast),
        .s_main_tdata(s_main_tdata), .s_main_tvalid(s_main_tvalid), .s_main_tready(s_main_tready),
        .s_main_tlast(s_main_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .cfg_mode(cfg_mode), .cfg_main_shift(cfg_main_shift), .cfg_skip_shift(cfg_skip_shift),
        .clear_status(clear_status), .fifo_level(fifo_level),
        .err_last_mismatch(err_last_mismatch), .sat_count(sat_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int exp_d[$];
    bit exp_l[$];
    int exp_sat = 0;
    bit exp_err = 0;
    int fd_cnt = 0;
    int rdy_mode = 0;  // 0: always ready, 1: toggles 1010, 2: never ready

    int sk_v[8]; bit sk_l[8]; int nsk;
    int mn_v[8]; bit mn_l[8]; int nmn;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int asr(input int v, input int s);
        int p = 1 << s;
        if (v >= 0) return v / p;
        return -((-v + p - 1) / p);
    endfunction

    function automatic int model(input int mode, input int ms, input int ss,
                                 input int mv, input int sv, output bit sat);
        int r;
        sat = 0;
        if (mode == 0) return mv;
        r = asr(mv, ms) + asr(sv, ss);
        if (r > 32767)       begin r = 32767;  sat = 1; end
        else if (r < -32768) begin r = -32768; sat = 1; end
        if (mode == 2 && r < 0) r = 0;
        return r;
    endfunction

    task automatic model_frame(input int mode, input int ms, input int ss);
        bit s;
        for (int i = 0; i < nmn; i++) begin
            exp_d.push_back(model(mode, ms, ss, mn_v[i], (mode != 0) ? sk_v[i] : 0, s));
            exp_l.push_back(mn_l[i]);
            if (s) exp_sat++;
            if (mode != 0 && sk_l[i] != mn_l[i]) exp_err = 1;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic drive_skips();
        for (int i = 0; i < nsk; i++) begin
            int n = 0;
            bit done = 0;
            s_skip_tdata = sk_v[i][15:0]; s_skip_tlast = sk_l[i]; s_skip_tvalid = 1'b1;
            while (!done) begin
                @(negedge clk);
                if (s_skip_tready) done = 1;
                else if (++n > 100) begin chk("skip_accept_timeout", n, 0); done = 1; end
            end
            step();
        end
        s_skip_tvalid = 1'b0;
    endtask

    task automatic drive_mains();
        for (int i = 0; i < nmn; i++) begin
            int n = 0;
            bit done = 0;
            s_main_tdata = mn_v[i][15:0]; s_main_tlast = mn_l[i]; s_main_tvalid = 1'b1;
            while (!done) begin
                @(negedge clk);
                if (s_main_tready) done = 1;
                else if (++n > 100) begin chk("main_accept_timeout", n, 0); done = 1; end
            end
            step();
        end
        s_main_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_d.size() != 0 && n < 200) begin step(); n++; end
        chk("drain_pending", exp_d.size(), 0);
        step(); step();
    endtask

    task automatic run_frame(input int mode, input int ms, input int ss);
        cfg_mode = mode[1:0]; cfg_main_shift = ms[3:0]; cfg_skip_shift = ss[3:0];
        model_frame(mode, ms, ss);
        fork
            drive_skips();
            drive_mains();
        join
        drain();
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: m_axis_tready = 1'b1;
                1: m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    bit          hold = 0;
    logic [15:0] hold_d;
    logic        hold_l;
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (!rst_n) hold = 0;
        else begin
            if (hold) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, hold_d);
                chk("hold_last", m_axis_tlast, hold_l);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_d.size() == 0) chk("spurious_beat", exp_d.size(), 1);
                else begin
                    chk("out_data", int'($signed(m_axis_tdata)), exp_d.pop_front());
                    chk("out_last", m_axis_tlast, exp_l.pop_front());
                end
            end
            hold   = m_axis_tvalid && !m_axis_tready;
            hold_d = m_axis_tdata;
            hold_l = m_axis_tlast;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit s;
        int fd0;
        rst_n = 1'b0; clear_status = 1'b0;
        s_skip_tdata = '0; s_skip_tvalid = 1'b0; s_skip_tlast = 1'b0;
        s_main_tdata = '0; s_main_tvalid = 1'b1; s_main_tlast = 1'b0;
        cfg_mode = 2'd0; cfg_main_shift = '0; cfg_skip_shift = '0;
        step(); step();
        @(negedge clk);
        chk("rst_skip_tready", s_skip_tready, 0);
        chk("rst_main_tready", s_main_tready, 0);
        step();
        s_main_tvalid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_fifo_level", fifo_level, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_err", err_last_mismatch, 0);
        chk("rst_frame_done", frame_done, 0);

        chk("model_pin_add", model(1, 0, 0, 20, 100, s), 120);
        chk("model_pin_satp", model(1, 0, 0, 'h7000, 'h2000, s), 32767);
        chk("model_pin_satn", model(1, 0, 0, -32767, -4096, s), -32768);
        chk("model_pin_relu0", model(2, 1, 0, -40, 10, s), 0);
        chk("model_pin_relu1", model(2, 1, 0, 40, 10, s), 30);

        // Basic add, two-beat frame
        fd0 = fd_cnt;
        nsk = 2; sk_v[0] = 100; sk_l[0] = 0; sk_v[1] = -50; sk_l[1] = 1;
        nmn = 2; mn_v[0] = 20;  mn_l[0] = 0; mn_v[1] = -30; mn_l[1] = 1;
        run_frame(1, 0, 0);
        chk("frame_done_pulses", fd_cnt - fd0, 1);

        // Saturation both directions
        sk_v[0] = 'h2000;  sk_v[1] = -4096;
        mn_v[0] = 'h7000;  mn_v[1] = -32767;
        run_frame(1, 0, 0);
        chk("sat_count_lit", sat_count, 2);
        chk("sat_count_model", sat_count, exp_sat);

        // ReLU with main shift
        sk_v[0] = 10; sk_v[1] = 10;
        mn_v[0] = -40; mn_v[1] = 40;
        run_frame(2, 1, 0);
        cfg_main_shift = '0;

        // FIFO fill with main idle, then drain under toggling backpressure
        cfg_mode = 2'd1;
        nsk = 4; nmn = 4;
        for (int i = 0; i < 4; i++) begin
            sk_v[i] = i + 1; sk_l[i] = (i == 3);
            mn_v[i] = 10 * (i + 1); mn_l[i] = (i == 3);
        end
        drive_skips();
        @(negedge clk);
        chk("full_level", fifo_level, 4);
        chk("full_skip_tready", s_skip_tready, 0);
        step();
        model_frame(1, 0, 0);
        rdy_mode = 1;
        drive_mains();
        drain();
        rdy_mode = 0;
        step();
        chk("full_level_after", fifo_level, 0);

        // Bypass: skip discarded, cfg change mid-frame ignored until tlast
        nsk = 2; sk_v[0] = 500; sk_l[0] = 0; sk_v[1] = 600; sk_l[1] = 1;
        nmn = 1; mn_v[0] = 7; mn_l[0] = 0;
        cfg_mode = 2'd0;
        model_frame(0, 0, 0);
        fork
            drive_skips();
            drive_mains();
        join
        chk("bypass_level", fifo_level, 0);
        cfg_mode = 2'd1;
        mn_v[0] = -8; mn_l[0] = 1;
        model_frame(0, 0, 0);
        drive_mains();
        drain();
        nsk = 1; sk_v[0] = 5; sk_l[0] = 1;
        nmn = 1; mn_v[0] = 6; mn_l[0] = 1;
        run_frame(1, 0, 0);

        // tlast mismatch, then clear
        nsk = 3; nmn = 3;
        for (int i = 0; i < 3; i++) begin
            sk_v[i] = i + 1; sk_l[i] = (i == 1);
            mn_v[i] = 1;     mn_l[i] = (i == 2);
        end
        run_frame(1, 0, 0);
        chk("err_lit", err_last_mismatch, 1);
        chk("err_model", err_last_mismatch, exp_err);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        exp_err = 0; exp_sat = 0;
        chk("clr_err", err_last_mismatch, 0);
        chk("clr_sat", sat_count, 0);

        // Reset mid-frame with a beat buffered and one held at the output
        cfg_mode = 2'd1;
        nsk = 2; sk_v[0] = 11; sk_l[0] = 0; sk_v[1] = 12; sk_l[1] = 0;
        nmn = 1; mn_v[0] = 1; mn_l[0] = 0;
        rdy_mode = 2;
        drive_skips();
        drive_mains();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_tdata", m_axis_tdata, 0);
        chk("mid_rst_tlast", m_axis_tlast, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_err", err_last_mismatch, 0);
        chk("mid_rst_sat", sat_count, 0);
        rdy_mode = 0;
        step();
        nsk = 1; sk_v[0] = 3; sk_l[0] = 1;
        nmn = 1; mn_v[0] = 4; mn_l[0] = 1;
        run_frame(1, 0, 0);

        chk("final_queue_empty", exp_d.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
